// File: rtl/sevenseg_pkg.sv
// Shared segment encodings and hex decode for the multiplexed seven-segment driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed N-digit common-anode display scanner with frame-synchronous value
// latching, anti-ghosting guard cycles, leading-zero blanking and scan enable.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            catode,
  output logic [IW-1:0]         digit_idx
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [4*N_DIGITS-1:0] pend_value_reg, frame_value_reg;
  logic [N_DIGITS-1:0]   pend_dp_reg, frame_dp_reg;
  logic [N_DIGITS-1:0]   anode_reg, anode_next;
  logic [7:0]            catode_reg, catode_next;
  logic [IW-1:0]         digit_idx_reg;
  logic                  slot_end, frame_end;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [3:0]            cur_nibble;
  logic                  cur_blank, cur_dp;
  logic [6:0]            cur_seg;

  always_comb begin
    slot_end  = (cnt_reg == CW'(REFRESH_DIV - 1));
    frame_end = slot_end && (idx_reg == IW'(N_DIGITS - 1));
    cnt_next  = slot_end ? '0 : cnt_reg + CW'(1);
    idx_next  = idx_reg;
    if (slot_end) idx_next = frame_end ? '0 : idx_reg + IW'(1);
  end

  // Digit k is a leading zero when it and every more significant nibble are zero.
  assign blank_mask[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_blank
      assign blank_mask[gi] = blank_lz & ~(|frame_value_reg[4*N_DIGITS-1:4*gi]);
    end
  endgenerate

  always_comb begin
    cur_nibble = frame_value_reg[4*idx_reg +: 4];
    cur_blank  = blank_mask[idx_reg];
    cur_dp     = frame_dp_reg[idx_reg];
  end

  sevenseg_decode u_decode (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .seg    (cur_seg)
  );

  always_comb begin
    anode_next  = '1;
    catode_next = 8'hFF;
    if (enable) begin
      catode_next = {~cur_dp, cur_seg};
      if (cnt_reg >= CW'(GUARD)) anode_next = ~(N_DIGITS'(1) << idx_reg);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      pend_value_reg  <= '0;
      pend_dp_reg     <= '0;
      frame_value_reg <= '0;
      frame_dp_reg    <= '0;
      anode_reg       <= '1;
      catode_reg      <= 8'hFF;
      digit_idx_reg   <= '0;
    end else begin
      if (load) begin
        pend_value_reg <= value;
        pend_dp_reg    <= dp;
      end
      if (enable) begin
        cnt_reg <= cnt_next;
        idx_reg <= idx_next;
        // Frame takes the pending value held before this edge, so a load on
        // the wrap edge waits one more frame.
        if (frame_end) begin
          frame_value_reg <= pend_value_reg;
          frame_dp_reg    <= pend_dp_reg;
        end
      end
      anode_reg     <= anode_next;
      catode_reg    <= catode_next;
      digit_idx_reg <= idx_reg;
    end
  end

  assign anode     = anode_reg;
  assign catode    = catode_reg;
  assign digit_idx = digit_idx_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (4 digits, 4-cycle slots, 1 guard cycle).
module tb_sevenseg_scan;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic [1:0]  digit_idx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sevenseg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp        (dp),
    .load      (load),
    .blank_lz  (blank_lz),
    .enable    (enable),
    .anode     (anode),
    .catode    (catode),
    .digit_idx (digit_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: t counts enabled edges since reset; slot/digit follow by division.
  initial begin
    int t, cnt, idx;
    logic [15:0] pv, fv, opv;
    logic [3:0]  pd, fd, opd, ea, nib;
    logic [7:0]  ec;
    logic [1:0]  ei;
    logic        blank;
    t = 0; pv = '0; pd = '0; fv = '0; fd = '0; ea = 4'hF; ec = 8'hFF; ei = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        t = 0; pv = '0; pd = '0; fv = '0; fd = '0;
        ea = 4'hF; ec = 8'hFF; ei = '0;
      end else begin
        cnt = t % RD;
        idx = (t / RD) % N;
        ei  = 2'(idx);
        if (!enable) begin
          ea = 4'hF;
          ec = 8'hFF;
        end else begin
          ea    = (cnt < G) ? 4'hF : ~(4'b0001 << idx);
          nib   = fv[idx*4 +: 4];
          blank = blank_lz && (idx > 0) && ((fv >> (4*idx)) == 16'h0);
          ec    = {~fd[idx], blank ? 7'h7F : seg_tab[nib]};
        end
        opv = pv; opd = pd;
        if (load) begin pv = value; pd = dp; end
        if (enable) begin
          t++;
          if (t % (N*RD) == 0) begin fv = opv; fd = opd; end
        end
      end
      #1;
      if (chk_on) begin
        chk("model_anode", 32'(anode), 32'(ea));
        chk("model_catode", 32'(catode), 32'(ec));
        chk("model_digit_idx", 32'(digit_idx), 32'(ei));
      end
    end
  end

  // Waits for a guard cycle, then for the first lit cycle of digit d.
  task automatic wait_lit(input int d, output int when);
    logic [3:0] lit;
    bit found;
    lit = ~(4'b0001 << d);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (anode == 4'hF) found = 1'b1;
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clk);
        if (anode == lit) found = 1'b1;
      end
    end
    when = cyc;
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_lit digit=%0d actual anode=%b required=%b", d, anode, lit);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int t1, t2, tw;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_anode", 32'(anode), 32'h0000000F);
    chk("reset_catode", 32'(catode), 32'h000000FF);
    chk("reset_idx", 32'(digit_idx), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("release_guard", 32'(anode), 32'h0000000F);
    @(negedge clk);
    chk("release_first_lit", 32'(anode), 32'h0000000E);
    chk("release_catode", 32'(catode), 32'h000000C0);

    // Scan order and frame period
    wait_lit(0, t1);
    for (int d = 1; d < N; d++) begin
      wait_lit(d, tw);
      chk("scan_idx", 32'(digit_idx), 32'(d));
    end
    wait_lit(0, t2);
    chk("frame_period", 32'(t2 - t1), 32'd16);

    // Hex decode and dp
    do_load(16'h1234, 4'b0001);
    wait_lit(1, tw);
    wait_lit(0, tw); chk("hex_d0", 32'(catode), 32'h19);
    wait_lit(1, tw); chk("hex_d1", 32'(catode), 32'hB0);
    wait_lit(2, tw); chk("hex_d2", 32'(catode), 32'hA4);
    wait_lit(3, tw); chk("hex_d3", 32'(catode), 32'hF9);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    wait_lit(1, tw);
    wait_lit(0, tw); chk("lz70_d0", 32'(catode), 32'hC0);
    wait_lit(1, tw); chk("lz70_d1", 32'(catode), 32'hF8);
    wait_lit(2, tw); chk("lz70_d2", 32'(catode), 32'hFF);
    wait_lit(3, tw); chk("lz70_d3", 32'(catode), 32'hFF);
    do_load(16'h0000, 4'b0000);
    wait_lit(1, tw);
    wait_lit(0, tw); chk("lz00_d0", 32'(catode), 32'hC0);
    wait_lit(1, tw); chk("lz00_d1", 32'(catode), 32'hFF);
    wait_lit(2, tw); chk("lz00_d2", 32'(catode), 32'hFF);
    wait_lit(3, tw); chk("lz00_d3", 32'(catode), 32'hFF);
    blank_lz = 1'b0;

    // No tearing: a load mid-frame waits for the next boundary
    do_load(16'h1234, 4'b0000);
    wait_lit(1, tw);
    wait_lit(0, tw); chk("tear_old_d0", 32'(catode), 32'h99);
    do_load(16'hABCD, 4'b0000);
    wait_lit(1, tw); chk("tear_old_d1", 32'(catode), 32'hB0);
    wait_lit(3, tw); chk("tear_old_d3", 32'(catode), 32'hF9);
    wait_lit(0, tw); chk("tear_new_d0", 32'(catode), 32'hA1);
    wait_lit(3, tw); chk("tear_new_d3", 32'(catode), 32'h88);

    // Enable pause for 10 cycles during slot 2
    wait_lit(0, t1);
    wait_lit(2, tw);
    enable = 1'b0;
    @(negedge clk);
    chk("pause_anode", 32'(anode), 32'h0000000F);
    chk("pause_catode", 32'(catode), 32'h000000FF);
    repeat (9) @(negedge clk);
    enable = 1'b1;
    wait_lit(0, t2);
    chk("pause_period", 32'(t2 - t1), 32'd26);

    // Reset mid-slot
    wait_lit(1, tw);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_anode", 32'(anode), 32'h0000000F);
    chk("midrst_catode", 32'(catode), 32'h000000FF);
    chk("midrst_idx", 32'(digit_idx), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_guard", 32'(anode), 32'h0000000F);
    @(negedge clk);
    chk("midrst_first_lit", 32'(anode), 32'h0000000E);
    chk("midrst_frame_cleared", 32'(catode), 32'h000000C0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
